// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master engine (START / WRITE / READ / STOP).
// One command at a time over a valid/ready handshake. The bus lines are open-drain
// drive values: 1 releases the line, 0 pulls it low.
// Optional feature macro: I2C_CLK_STRETCH_EN. When it is defined, the phase counter
// freezes while the engine releases scl but scl_i still reads low (slave clock stretching).
// The bus lines are registered from the current phase, so they trail the FSM by one
// cycle. The extra DONE cycle makes up for that lag, so the response lines up with
// the bus activity.
module i2c_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl,
  output logic       sda,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_BIT, ST_STOP, ST_DONE} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    ph_r, ph_s;
  logic [3:0]    bit_r, bit_s;
  logic [1:0]    op_r, op_s;
  logic [7:0]    shift_r, shift_s;
  logic          nack_cmd_r, nack_cmd_s;
  logic          ack_r, ack_s;
  logic          rsp_fire_s;
  logic          hold_s;
  logic          tx_s;
  logic          drv_scl_s, drv_sda_s;
  logic          cmd_ready_r, rsp_valid_r, rsp_nack_r, scl_r, sda_r;
  logic [7:0]    rsp_data_r;

`ifdef I2C_CLK_STRETCH_EN
  logic scl_high_phase_s;
  // Freeze the phase counter while scl is released but a slave still holds it low
  always_comb begin
    scl_high_phase_s = ((state_r == ST_START) && (ph_r != 2'd2)) ||
                       ((state_r == ST_STOP)  && (ph_r != 2'd0)) ||
                       ((state_r == ST_BIT)   && (ph_r == 2'd1));
    hold_s = scl_high_phase_s && scl_r && !scl_i;
  end
`else
  logic unused_scl_i_s;
  assign unused_scl_i_s = scl_i;
  assign hold_s = 1'b0;
`endif

  // Bit value put on sda for the current bit slot: WRITE data then release, READ release then ACK/NACK
  always_comb begin
    if (op_r == OP_READ) begin
      tx_s = (bit_r == 4'd8) ? nack_cmd_r : 1'b1;
    end else begin
      tx_s = (bit_r == 4'd8) ? 1'b1 : shift_r[7];
    end
  end

  // Next-state, phase sequencing, sda_i sampling and response trigger
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    ph_s       = ph_r;
    bit_s      = bit_r;
    op_s       = op_r;
    shift_s    = shift_r;
    nack_cmd_s = nack_cmd_r;
    ack_s      = ack_r;
    rsp_fire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          op_s       = cmd_op;
          shift_s    = (cmd_op == OP_WRITE) ? cmd_data : 8'h00;
          nack_cmd_s = cmd_nack;
          ack_s      = 1'b0;
          cnt_s      = '0;
          ph_s       = 2'd0;
          bit_s      = 4'd0;
          case (cmd_op)
            OP_START: state_s = ST_START;
            OP_STOP:  state_s = ST_STOP;
            default:  state_s = ST_BIT;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START, ST_STOP: begin
        if (hold_s) begin
          cnt_s = cnt_r;
        end else if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (ph_r == 2'd2) begin
            ph_s    = 2'd0;
            state_s = ST_DONE;
          end else begin
            ph_s = ph_r + 2'd1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_BIT: begin
        // The edge that closes the last visible p2 cycle falls at p3, count 0
        if ((ph_r == 2'd3) && (cnt_r == '0)) begin
          if ((op_r == OP_READ) && (bit_r != 4'd8)) begin
            shift_s = {shift_r[6:0], sda_i};
          end else if ((op_r == OP_WRITE) && (bit_r == 4'd8)) begin
            ack_s = sda_i;
          end else begin
            ack_s = ack_r;
          end
        end else begin
          ack_s = ack_r;
        end
        if (hold_s) begin
          cnt_s = cnt_r;
        end else if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (ph_r == 2'd3) begin
            ph_s = 2'd0;
            if (op_r == OP_WRITE) begin
              shift_s = {shift_r[6:0], 1'b0};
            end else begin
              shift_s = shift_s;
            end
            if (bit_r == 4'd8) begin
              bit_s   = 4'd0;
              state_s = ST_DONE;
            end else begin
              bit_s = bit_r + 4'd1;
            end
          end else begin
            ph_s = ph_r + 2'd1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_DONE: begin
        if (cnt_r == '0) begin
          rsp_fire_s = 1'b1;
          cnt_s      = CW'(1);
        end else begin
          cnt_s   = '0;
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Bus line values for the current phase; lines hold their last value outside active phases
  always_comb begin
    drv_scl_s = scl_r;
    drv_sda_s = sda_r;
    case (state_r)
      ST_START: begin
        drv_scl_s = (ph_r != 2'd2);
        drv_sda_s = (ph_r == 2'd0);
      end
      ST_STOP: begin
        drv_scl_s = (ph_r != 2'd0);
        drv_sda_s = (ph_r == 2'd2);
      end
      ST_BIT: begin
        drv_scl_s = (ph_r == 2'd1) || (ph_r == 2'd2);
        drv_sda_s = tx_s;
      end
      default: begin
        drv_scl_s = scl_r;
        drv_sda_s = sda_r;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      ph_r        <= 2'd0;
      bit_r       <= 4'd0;
      op_r        <= 2'b00;
      shift_r     <= 8'h00;
      nack_cmd_r  <= 1'b0;
      ack_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_nack_r  <= 1'b0;
      scl_r       <= 1'b1;
      sda_r       <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ph_r        <= ph_s;
      bit_r       <= bit_s;
      op_r        <= op_s;
      shift_r     <= shift_s;
      nack_cmd_r  <= nack_cmd_s;
      ack_r       <= ack_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= rsp_fire_s;
      scl_r       <= drv_scl_s;
      sda_r       <= drv_sda_s;
      if (rsp_fire_s) begin
        rsp_data_r <= (op_r == OP_READ) ? shift_r : 8'h00;
        rsp_nack_r <= (op_r == OP_WRITE) ? ack_r : 1'b0;
      end else begin
        rsp_data_r <= rsp_data_r;
        rsp_nack_r <= rsp_nack_r;
      end
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = ~cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_nack  = rsp_nack_r;
  assign scl       = scl_r;
  assign sda       = sda_r;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Testbench for i2c_byte_master. A behavioural I2C slave answers on sda_i, and can
// stretch the clock on scl_i. Expected responses are queued at accept time. A separate
// monitor pops the queue and compares whenever rsp_valid is seen.
module tb_i2c_byte_master;

  localparam int Q = 4;
  localparam int STRETCH_LEN = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       scl, sda, scl_i, sda_i;

  i2c_byte_master #(.CLK_DIV(Q)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack), .busy(busy),
    .scl(scl), .sda(sda), .scl_i(scl_i), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic       nack;
    int         lat;
    int         acc_pc;
    logic [7:0] wdata;
    logic       rnack;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;
  int pc = 0;
  int accepts = 0;
  int issued = 0;
  int rsp_count = 0;
  int last_rsp_pc = 0;

  // next-command slave/model settings (written by the driver before cmd_valid rises)
  logic [1:0] nxt_op;
  logic [7:0] nxt_data, nxt_sbyte;
  logic       nxt_nack, nxt_sack;
  int         nxt_stretch;

  // bus observer / slave state
  logic [1:0] cur_op = 2'b00;
  logic [7:0] cur_sbyte = 8'h00;
  logic       cur_sack = 1'b1;
  int         cur_stretch = 0;
  int         pulses = 0;
  logic [8:0] captured = 9'h000;
  int         viol = 0;
  logic       slave_drive = 1'b1;
  logic       stretch_r = 1'b0;
  int         stretch_left = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         scl_rise_pc = 0, scl_fall_pc = 0, sda_rise_pc = 0, sda_fall_pc = 0;

  assign sda_i = sda & slave_drive;
  assign scl_i = scl & ~stretch_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) pc <= pc + 1;

  // Accept detection, scoreboard push, bus observation and slave behaviour
  always @(negedge clk) begin
    if (!rst_n) begin
      stretch_r    <= 1'b0;
      stretch_left <= 0;
      slave_drive  <= 1'b1;
    end else if (cmd_valid && cmd_ready) begin
      exp_t e;
      e.op     = nxt_op;
      e.data   = (nxt_op == 2'b10) ? nxt_sbyte : 8'h00;
      e.nack   = (nxt_op == 2'b01) ? nxt_sack : 1'b0;
      e.lat    = (nxt_op == 2'b00 || nxt_op == 2'b11) ? 3 * Q + 1 : 36 * Q + 1;
`ifdef I2C_CLK_STRETCH_EN
      if (nxt_stretch != 0 && (nxt_op == 2'b01 || nxt_op == 2'b10)) e.lat = e.lat + STRETCH_LEN;
`endif
      e.acc_pc = pc + 1;
      e.wdata  = nxt_data;
      e.rnack  = nxt_nack;
      sb.push_back(e);
      accepts     <= accepts + 1;
      cur_op      <= nxt_op;
      cur_sbyte   <= nxt_sbyte;
      cur_sack    <= nxt_sack;
      cur_stretch <= nxt_stretch;
      pulses      <= 0;
      captured    <= 9'h000;
      viol        <= 0;
      slave_drive <= (nxt_op == 2'b10) ? nxt_sbyte[7] : 1'b1;
    end else begin
      if (stretch_left > 1) stretch_left <= stretch_left - 1;
      else if (stretch_left == 1) begin
        stretch_left <= 0;
        stretch_r    <= 1'b0;
      end
      if (scl && !prev_scl) begin
        pulses      <= pulses + 1;
        captured    <= {captured[7:0], sda};
        scl_rise_pc <= pc;
        if ((cur_op == 2'b01 || cur_op == 2'b10) && (pulses + 1 == cur_stretch)) begin
          stretch_r    <= 1'b1;
          stretch_left <= STRETCH_LEN;
        end
      end
      if (!scl && prev_scl) begin
        scl_fall_pc <= pc;
        if (cur_op == 2'b01) slave_drive <= (pulses == 8) ? cur_sack : 1'b1;
        else if (cur_op == 2'b10) slave_drive <= (pulses < 8) ? cur_sbyte[7 - pulses] : 1'b1;
        else slave_drive <= 1'b1;
      end
      if (scl && prev_scl && (sda != prev_sda) && (cur_op == 2'b01 || cur_op == 2'b10))
        viol <= viol + 1;
      if (sda && !prev_sda) sda_rise_pc <= pc;
      if (!sda && prev_sda) sda_fall_pc <= pc;
    end
    prev_scl <= scl;
    prev_sda <= sda;
  end

  // Response monitor: pop expected item and compare on every rsp_valid
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_count++;
      last_rsp_pc = pc;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
        chk("rsp_nack", {31'd0, rsp_nack}, {31'd0, e.nack});
        chk("latency", pc - e.acc_pc, e.lat);
        chk("ready_busy_at_rsp", {30'd0, cmd_ready, busy}, 32'd1);
        case (e.op)
          2'b01, 2'b10: begin
            chk("scl_pulses", pulses, 9);
            chk("sda_change_scl_high", viol, 0);
            if (e.op == 2'b01) begin
              chk("write_bits", {24'd0, captured[8:1]}, {24'd0, e.wdata});
              chk("write_bit9_released", {31'd0, captured[0]}, 32'd1);
            end else begin
              chk("read_bit9_acknack", {31'd0, captured[0]}, {31'd0, e.rnack});
            end
            chk("scl_low_after_byte", {31'd0, scl}, 32'd0);
          end
          2'b00: begin
            chk("start_final_lines", {30'd0, scl, sda}, 32'd0);
            chk("start_sda_before_scl", {31'd0, sda_fall_pc < scl_fall_pc}, 32'd1);
          end
          default: begin
            chk("stop_final_lines", {30'd0, scl, sda}, 32'd3);
            chk("stop_sda_after_scl", {31'd0, sda_rise_pc > scl_rise_pc}, 32'd1);
          end
        endcase
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic nack,
                       input logic [7:0] sbyte, input logic sack, input int stretch, input bit b2b);
    bit got;
    got = 1'b0;
    nxt_op = op; nxt_data = data; nxt_nack = nack;
    nxt_sbyte = sbyte; nxt_sack = sack; nxt_stretch = stretch;
    cmd_op = op; cmd_data = data; cmd_nack = nack;
    cmd_valid = 1'b1;
    issued++;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (b2b) chk("b2b_accept_gap", pc + 1 - last_rsp_pc, 32'd2);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_queue_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0;
    // reset state
    #12;
    chk("reset_lines", {30'd0, scl, sda}, 32'd3);
    chk("reset_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
    chk("reset_rsp", {22'd0, rsp_valid, rsp_nack, rsp_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    // START then WRITE 0xA5 acknowledged
    issue(2'b00, 8'h00, 1'b0, 8'hFF, 1'b1, 0, 1'b0);
    issue(2'b01, 8'hA5, 1'b0, 8'hFF, 1'b0, 0, 1'b1);
    // READ 0x3C with NACK
    issue(2'b10, 8'h00, 1'b1, 8'h3C, 1'b1, 0, 1'b1);
    idle(4);
    // WRITE 0x00 not acknowledged, then STOP
    issue(2'b01, 8'h00, 1'b0, 8'hFF, 1'b1, 0, 1'b0);
    issue(2'b11, 8'h00, 1'b0, 8'hFF, 1'b1, 0, 1'b1);
    idle(2);
    // WRITE with a 20-cycle clock stretch in the third bit
    issue(2'b01, 8'h5A, 1'b0, 8'hFF, 1'b0, 3, 1'b0);
    // randomized command stream
    for (int i = 0; i < 12; i++) begin
      logic [1:0] op;
      bit b2b;
      op  = 2'($urandom_range(0, 3));
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) idle($urandom_range(1, 5));
      issue(op, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 0, b2b);
    end
    idle(1);
    drain();

    // reset in the middle of a WRITE
    issue(2'b01, 8'hC3, 1'b0, 8'hFF, 1'b0, 0, 1'b0);
    idle(60);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_lines", {30'd0, scl, sda}, 32'd3);
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset_ready", {31'd0, cmd_ready}, 32'd1);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rc0 = rsp_count;
    repeat (200) @(posedge clk);
    #1;
    chk("no_rsp_after_reset", rsp_count, rc0);

    // engine recovers
    issue(2'b00, 8'h00, 1'b0, 8'hFF, 1'b1, 0, 1'b0);
    issue(2'b10, 8'h00, 1'b0, 8'h96, 1'b1, 0, 1'b1);
    issue(2'b11, 8'h00, 1'b0, 8'hFF, 1'b1, 0, 1'b1);
    idle(1);
    drain();
    chk("accept_count", accepts, issued);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
